regfile_wb_queue: RTL and testbench
===================================

Name: regfile_wb_queue

Overview:
- Write-side client of the 32x64 register file.
- Buffers write-back requests from the execute/load stages in a small circular FIFO and drains them, one per cycle, into the regfile single write port (RegWrite/WriteRegister/WriteData).
- Provides two combinational forwarding lookups so readers see data that is still pending in the queue.
- Writes to register 31 (XZR) are discarded.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
REG_SIZE, 64, data width
ADDR_W, 5, register index width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  write-back request valid
in_ready  output  1  queue can accept a request
in_reg  input  ADDR_W  destination register
in_data  input  REG_SIZE  write-back data
wr_stall  input  1  regfile port unavailable this cycle; hold head
RegWrite  output  1  regfile write enable
WriteRegister  output  ADDR_W  regfile write index
WriteData  output  REG_SIZE  regfile write data
fwd_reg1, fwd_reg2  input  ADDR_W  lookup indices, tied to ReadRegister1/2
fwd_hit1, fwd_hit2  output  1  a pending entry matches
fwd_data1, fwd_data2  output  REG_SIZE  data of the newest matching entry
count  output  $clog2(DEPTH)+1  occupied entries
empty  output  1  count == 0

Behaviour:
- Reset: asynchronous, active-low, applies mid-operation.
  - All entries are invalidated; head/tail pointers and count go to 0.
  - Pending writes are lost.
  - Outputs during and after reset: RegWrite=0, WriteRegister=0, WriteData=0, fwd_hit*=0, fwd_data*=0, empty=1, in_ready=1.
- Storage: circular buffer with head/tail pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - full: pointers equal except the MSB.
  - empty: pointers fully equal.
- Push: in_valid && in_ready at a clk edge.
  - in_reg != 31: the entry is written at tail and tail increments.
  - in_reg == 31: the request is accepted (handshake completes) but nothing is stored.
- in_ready = !full. No same-cycle pass-through when full, even if a pop occurs that cycle.
- Pop/drive (combinational from head):
  - RegWrite = !empty && !wr_stall.
  - WriteRegister and WriteData show the head entry; both are 0 when empty.
  - The head increments at the edge where RegWrite=1, coinciding with the regfile capture.
- Latency: a request accepted at edge N drives RegWrite during cycle N+1 at the earliest.
- Push and pop in the same cycle: count unchanged, order preserved.
- wr_stall=1: head and all outputs except RegWrite hold; pushes are still accepted while not full.
- Forwarding:
  - Combinational compare of fwd_regX against all valid entries.
  - The newest match (closest to tail) wins.
  - fwd_regX == 31 never hits. No hit gives fwd_data=0.
  - The head entry being written this cycle still forwards, because the regfile read reflects it only after the edge.
- Ordering guarantee: writes reach the regfile in acceptance order, so the last write to a register wins.

Optional Feature:
- Macro: WB_COALESCE_EN.
- Defined: a push whose in_reg equals the newest valid entry's register overwrites that entry's data instead of allocating a new one; count is unchanged.
  - Coalescing is suppressed if that entry is the head and RegWrite=1 in that cycle; the push allocates normally.
  - in_ready is still !full.
- Undefined: every non-31 push allocates a new entry.

Decomposition:
- Package regfile_pkg holds:
  - Constants NUM_REG=32, REG_SIZE=64, ADDR_W=5, ZERO_REG=5'd31.
  - Typedef wb_entry_t: packed struct {logic [ADDR_W-1:0] rd; logic [REG_SIZE-1:0] data;}.
- One sub-module, wb_fwd_match: given the entry array, valid vector, tail pointer and lookup index, it returns hit and data with newest-first priority. It is instantiated twice, once per read channel.

Test Plan:
1. Reset, then push (reg 3, 0xAAAA) -> next cycle RegWrite=1, WriteRegister=3, WriteData=0xAAAA; the following cycle empty=1.
2. wr_stall=1, push regs 1,2,3,4 -> count=4, in_ready=0, and a fifth push is not accepted. Release the stall -> writes 1,2,3,4 drain on consecutive cycles in that order.
3. Push (5, 0x11) then (5, 0x22), wr_stall=1, fwd_reg1=5 -> fwd_hit1=1, fwd_data1=0x22. fwd_reg2=6 -> fwd_hit2=0, fwd_data2=0.
4. Push (31, 0xFFFF) -> in_ready handshake completes, count stays 0, RegWrite never asserts. fwd_reg1=31 -> no hit.
5. Three entries queued, then reset driven low mid-cycle -> RegWrite=0 immediately, count=0. After release, no stale write appears.
6. WB_COALESCE_EN defined, wr_stall=1, push (7, 0x1) then (7, 0x2) -> count=1; after the stall releases, a single write of 0x2 occurs. Undefined -> count=2 and two writes occur.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-back queue entry type.
package regfile_pkg;

   localparam int NUM_REG  = 32;
   localparam int REG_SIZE = 64;
   localparam int ADDR_W   = 5;

   localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

   typedef struct packed {
      logic [ADDR_W-1:0]   rd;
      logic [REG_SIZE-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Forwarding lookup over the write-back queue; the newest valid matching entry wins.
module wb_fwd_match
   import regfile_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  wb_entry_t [DEPTH-1:0]       entries,
   input  logic [DEPTH-1:0]            valid,
   input  logic [$clog2(DEPTH)-1:0]    tail_idx,
   input  logic [ADDR_W-1:0]           lookup,
   output logic                        hit,
   output logic [REG_SIZE-1:0]         data
);

   localparam int IDX_W = $clog2(DEPTH);

   // Walk from the oldest slot to the newest so a later match overrides an earlier one.
   always_comb begin
      logic [IDX_W-1:0] idx;
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = DEPTH; k >= 1; k--) begin
         idx = tail_idx - IDX_W'(k);
         if (valid[idx] && (entries[idx].rd == lookup) && (lookup != ZERO_REG)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/regfile_wb_queue.sv
// Circular write-back queue draining one entry per cycle into the regfile write port.
// Optional macro WB_COALESCE_EN: a push to the newest entry's register overwrites its data.
module regfile_wb_queue #(
   parameter int DEPTH    = 4,
   parameter int REG_SIZE = 64,
   parameter int ADDR_W   = 5
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_W-1:0]         in_reg,
   input  logic [REG_SIZE-1:0]       in_data,
   input  logic                      wr_stall,
   output logic                      RegWrite,
   output logic [ADDR_W-1:0]         WriteRegister,
   output logic [REG_SIZE-1:0]       WriteData,
   input  logic [ADDR_W-1:0]         fwd_reg1,
   input  logic [ADDR_W-1:0]         fwd_reg2,
   output logic                      fwd_hit1,
   output logic                      fwd_hit2,
   output logic [REG_SIZE-1:0]       fwd_data1,
   output logic [REG_SIZE-1:0]       fwd_data2,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      empty
);

   import regfile_pkg::wb_entry_t;
   import regfile_pkg::ZERO_REG;

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0]       head_q, tail_q;
   logic [IDX_W-1:0]       head_idx, tail_idx;
   wb_entry_t [DEPTH-1:0]  entries_q;
   logic [DEPTH-1:0]       valid_q;
   wb_entry_t              head_entry;

   logic full, is_empty, push, store, pop, coalesce, alloc;

   assign head_idx = head_q[IDX_W-1:0];
   assign tail_idx = tail_q[IDX_W-1:0];

   assign is_empty = (head_q == tail_q);
   assign full     = (head_q[PTR_W-1] != tail_q[PTR_W-1]) && (head_idx == tail_idx);

   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign store    = push && (in_reg != ZERO_REG);
   assign pop      = !is_empty && !wr_stall;

`ifdef WB_COALESCE_EN
   logic [IDX_W-1:0] newest_idx;

   assign newest_idx = tail_idx - IDX_W'(1);
   // Never merge into the head while it is being captured by the regfile this edge.
   assign coalesce   = store && !is_empty
                       && (entries_q[newest_idx].rd == in_reg)
                       && !((newest_idx == head_idx) && pop);
`else
   assign coalesce   = 1'b0;
`endif

   assign alloc = store && !coalesce;

   assign head_entry    = is_empty ? '0 : entries_q[head_idx];
   assign RegWrite      = pop;
   assign WriteRegister = head_entry.rd;
   assign WriteData     = head_entry.data;
   assign count         = tail_q - head_q;
   assign empty         = is_empty;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q    <= '0;
         tail_q    <= '0;
         valid_q   <= '0;
         entries_q <= '0;
      end else begin
         if (pop) begin
            head_q            <= head_q + PTR_W'(1);
            valid_q[head_idx] <= 1'b0;
         end
         if (alloc) begin
            entries_q[tail_idx].rd   <= in_reg;
            entries_q[tail_idx].data <= in_data;
            valid_q[tail_idx]        <= 1'b1;
            tail_q                   <= tail_q + PTR_W'(1);
         end
`ifdef WB_COALESCE_EN
         if (coalesce) begin
            entries_q[newest_idx].data <= in_data;
         end
`endif
      end
   end

   wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
      .entries  (entries_q),
      .valid    (valid_q),
      .tail_idx (tail_idx),
      .lookup   (fwd_reg1),
      .hit      (fwd_hit1),
      .data     (fwd_data1)
   );

   wb_fwd_match #(.DEPTH(DEPTH)) u_fwd2 (
      .entries  (entries_q),
      .valid    (valid_q),
      .tail_idx (tail_idx),
      .lookup   (fwd_reg2),
      .hit      (fwd_hit2),
      .data     (fwd_data2)
   );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_regfile_wb_queue;
   import regfile_pkg::*;

   localparam int DEPTH = 4;
`ifdef WB_COALESCE_EN
   localparam int COAL = 1;
`else
   localparam int COAL = 0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid, in_ready, wr_stall, RegWrite;
   logic [4:0]  in_reg, WriteRegister, fwd_reg1, fwd_reg2;
   logic [63:0] in_data, WriteData, fwd_data1, fwd_data2;
   logic        fwd_hit1, fwd_hit2, empty;
   logic [2:0]  count;

   int total = 0;
   int bad = 0;
   wb_entry_t q[$];

   always #5 clk = ~clk;

   regfile_wb_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_reg(in_reg), .in_data(in_data), .wr_stall(wr_stall),
      .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
      .fwd_reg1(fwd_reg1), .fwd_reg2(fwd_reg2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
      .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count), .empty(empty)
   );

   task automatic drive(input logic v, input logic [4:0] r, input logic [63:0] d, input logic s);
      in_valid = v; in_reg = r; in_data = d; wr_stall = s;
   endtask

   // Reference: queue of pending writes, oldest first; a later match overrides an earlier one.
   function automatic void model_fwd(input logic [4:0] r, output logic h, output logic [63:0] d);
      h = 1'b0; d = '0;
      if (r != 5'd31)
         for (int i = 0; i < q.size(); i++)
            if (q[i].rd == r) begin h = 1'b1; d = q[i].data; end
   endfunction

   // Advance one clock: decide pop/push from pre-edge state, apply at the edge, end on the negedge.
   task automatic tick();
      bit do_pop, do_push, do_coal;
      wb_entry_t e;
      do_pop  = (q.size() > 0) && !wr_stall;
      do_push = in_valid && (q.size() < DEPTH) && (in_reg != 5'd31);
      do_coal = 1'b0;
      if (COAL == 1 && do_push && q.size() > 0 && q[q.size()-1].rd == in_reg
          && !(q.size() == 1 && do_pop))
         do_coal = 1'b1;
      e.rd = in_reg; e.data = in_data;
      @(posedge clk);
      if (reset === 1'b1) begin
         if (do_pop) void'(q.pop_front());
         if (do_coal) begin
            wb_entry_t t;
            t = q[q.size()-1]; t.data = e.data; q[q.size()-1] = t;
         end else if (do_push) q.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(0, 0, 0, 0); fwd_reg1 = 5'd0; fwd_reg2 = 5'd3;
      #2 reset = 1'b0; #1;
      total++; if (RegWrite !== 1'b0) begin bad++; $display("FAIL reset_regwrite: got %b want 0", RegWrite); end
      total++; if (WriteRegister !== 5'd0) begin bad++; $display("FAIL reset_wreg: got %0d want 0", WriteRegister); end
      total++; if (WriteData !== 64'd0) begin bad++; $display("FAIL reset_wdata: got %0h want 0", WriteData); end
      total++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 64'd0) begin bad++; $display("FAIL reset_fwd1: got %b/%0h want 0/0", fwd_hit1, fwd_data1); end
      total++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 64'd0) begin bad++; $display("FAIL reset_fwd2: got %b/%0h want 0/0", fwd_hit2, fwd_data2); end
      total++; if (empty !== 1'b1 || in_ready !== 1'b1 || count !== 3'd0) begin bad++; $display("FAIL reset_flags: got empty=%b ready=%b count=%0d want 1 1 0", empty, in_ready, count); end
      q.delete();
      @(negedge clk); @(negedge clk); reset = 1'b1; #1;
      total++; if (empty !== 1'b1 || RegWrite !== 1'b0) begin bad++; $display("FAIL reset_release: got empty=%b rw=%b want 1 0", empty, RegWrite); end
      @(negedge clk);
   endtask

   task automatic test_single_write();
      drive(1, 5'd3, 64'hAAAA, 0); #1;
      total++; if (in_ready !== 1'b1 || RegWrite !== 1'b0) begin bad++; $display("FAIL single_pre: got ready=%b rw=%b want 1 0", in_ready, RegWrite); end
      tick();
      drive(0, 0, 0, 0); #1;
      total++; if (RegWrite !== 1'b1 || WriteRegister !== 5'd3 || WriteData !== 64'hAAAA)
         begin bad++; $display("FAIL single_write: got rw=%b reg=%0d data=%0h want 1 3 aaaa", RegWrite, WriteRegister, WriteData); end
      tick(); #1;
      total++; if (empty !== 1'b1 || RegWrite !== 1'b0) begin bad++; $display("FAIL single_drained: got empty=%b rw=%b want 1 0", empty, RegWrite); end
   endtask

   task automatic test_stall_fill();
      for (int i = 1; i <= 4; i++) begin
         drive(1, 5'(i), 64'(i) * 64'h100, 1); tick();
      end
      drive(1, 5'd5, 64'h500, 1); #1;
      total++; if (count !== 3'd4 || in_ready !== 1'b0 || RegWrite !== 1'b0)
         begin bad++; $display("FAIL fill_full: got count=%0d ready=%b rw=%b want 4 0 0", count, in_ready, RegWrite); end
      tick(); #1;
      total++; if (count !== 3'd4) begin bad++; $display("FAIL fill_reject: got count=%0d want 4", count); end
      drive(0, 0, 0, 0);
      for (int i = 1; i <= 4; i++) begin
         #1;
         total++; if (RegWrite !== 1'b1 || WriteRegister !== 5'(i) || WriteData !== 64'(i) * 64'h100)
            begin bad++; $display("FAIL drain_%0d: got rw=%b reg=%0d data=%0h want 1 %0d %0h", i, RegWrite, WriteRegister, WriteData, i, i * 256); end
         tick();
      end
      #1;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty: got %b want 1", empty); end
   endtask

   task automatic test_forward();
      drive(1, 5'd5, 64'h11, 1); tick();
      drive(1, 5'd5, 64'h22, 1); tick();
      drive(0, 0, 0, 1); fwd_reg1 = 5'd5; fwd_reg2 = 5'd6; #1;
      total++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 64'h22) begin bad++; $display("FAIL fwd_newest: got %b/%0h want 1/22", fwd_hit1, fwd_data1); end
      total++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 64'h0) begin bad++; $display("FAIL fwd_miss: got %b/%0h want 0/0", fwd_hit2, fwd_data2); end
      total++; if (count !== 3'(2 - COAL)) begin bad++; $display("FAIL fwd_count: got %0d want %0d", count, 2 - COAL); end
      drive(0, 0, 0, 0); #1;
      total++; if (RegWrite !== 1'b1 || fwd_hit1 !== 1'b1 || fwd_data1 !== 64'h22)
         begin bad++; $display("FAIL fwd_head_written: got rw=%b hit=%b data=%0h want 1 1 22", RegWrite, fwd_hit1, fwd_data1); end
      for (int i = 0; i < 8 && q.size() > 0; i++) tick();
      #1;
      total++; if (empty !== 1'b1 || fwd_hit1 !== 1'b0) begin bad++; $display("FAIL fwd_drained: got empty=%b hit=%b want 1 0", empty, fwd_hit1); end
   endtask

   task automatic test_xzr();
      drive(1, 5'd31, 64'hFFFF, 0); fwd_reg1 = 5'd31; #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL xzr_ready: got %b want 1", in_ready); end
      tick();
      drive(0, 0, 0, 0); #1;
      total++; if (count !== 3'd0 || RegWrite !== 1'b0 || fwd_hit1 !== 1'b0)
         begin bad++; $display("FAIL xzr_dropped: got count=%0d rw=%b hit=%b want 0 0 0", count, RegWrite, fwd_hit1); end
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 3; i++) begin drive(1, 5'(9 + i), 64'(i + 1), 1); tick(); end
      drive(0, 0, 0, 0); fwd_reg1 = 5'd9; #1;
      total++; if (RegWrite !== 1'b1 || fwd_hit1 !== 1'b1 || count !== 3'd3)
         begin bad++; $display("FAIL mrst_pre: got rw=%b hit=%b count=%0d want 1 1 3", RegWrite, fwd_hit1, count); end
      #1 reset = 1'b0; #1;
      total++; if (RegWrite !== 1'b0 || count !== 3'd0 || empty !== 1'b1 || fwd_hit1 !== 1'b0 || WriteRegister !== 5'd0)
         begin bad++; $display("FAIL mrst_during: got rw=%b count=%0d empty=%b hit=%b reg=%0d want 0 0 1 0 0", RegWrite, count, empty, fwd_hit1, WriteRegister); end
      q.delete();
      @(negedge clk); reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++; if (RegWrite !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL mrst_stale_%0d: got rw=%b empty=%b want 0 1", i, RegWrite, empty); end
         tick();
      end
   endtask

   task automatic test_coalesce();
      int writes;
      logic [63:0] last;
      drive(1, 5'd7, 64'h1, 1); tick();
      drive(1, 5'd7, 64'h2, 1); tick();
      drive(0, 0, 0, 1); #1;
      total++; if (count !== 3'(2 - COAL)) begin bad++; $display("FAIL coal_count: got %0d want %0d", count, 2 - COAL); end
      drive(0, 0, 0, 0);
      writes = 0; last = '0;
      for (int i = 0; i < 6; i++) begin
         #1; if (RegWrite === 1'b1) begin writes++; last = WriteData; end
         tick();
      end
      total++; if (writes != 2 - COAL || last !== 64'h2)
         begin bad++; $display("FAIL coal_writes: got n=%0d last=%0h want %0d 2", writes, last, 2 - COAL); end
      drive(1, 5'd8, 64'h80, 0); tick();
      drive(1, 5'd8, 64'h81, 0); #1;
      total++; if (RegWrite !== 1'b1 || WriteData !== 64'h80) begin bad++; $display("FAIL coal_head_busy: got rw=%b data=%0h want 1 80", RegWrite, WriteData); end
      tick();
      drive(0, 0, 0, 1); #1;
      total++; if (count !== 3'd1 || WriteData !== 64'h81) begin bad++; $display("FAIL coal_suppressed: got count=%0d data=%0h want 1 81", count, WriteData); end
      drive(0, 0, 0, 0);
      for (int i = 0; i < 8 && q.size() > 0; i++) tick();
   endtask

   task automatic test_random();
      logic       eh1, eh2;
      logic [63:0] ed1, ed2;
      logic [4:0]  ereg;
      logic [63:0] edat;
      logic        erw;
      for (int n = 0; n < 400; n++) begin
         drive($urandom_range(0, 3) != 0,
               ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 2)),
               {$urandom, $urandom}, $urandom_range(0, 2) == 0);
         fwd_reg1 = ($urandom_range(0, 4) == 0) ? 5'd31 : 5'($urandom_range(0, 3));
         fwd_reg2 = 5'($urandom_range(0, 3));
         #1;
         erw  = (q.size() > 0) && !wr_stall;
         ereg = (q.size() > 0) ? q[0].rd : 5'd0;
         edat = (q.size() > 0) ? q[0].data : 64'd0;
         model_fwd(fwd_reg1, eh1, ed1);
         model_fwd(fwd_reg2, eh2, ed2);
         total++; if (RegWrite !== erw) begin bad++; $display("FAIL rnd_rw c%0d: got %b want %b", n, RegWrite, erw); end
         total++; if (WriteRegister !== ereg || WriteData !== edat)
            begin bad++; $display("FAIL rnd_head c%0d: got %0d/%0h want %0d/%0h", n, WriteRegister, WriteData, ereg, edat); end
         total++; if (count !== 3'(q.size()) || empty !== (q.size() == 0) || in_ready !== (q.size() < DEPTH))
            begin bad++; $display("FAIL rnd_occ c%0d: got count=%0d empty=%b ready=%b want %0d", n, count, empty, in_ready, q.size()); end
         total++; if (fwd_hit1 !== eh1 || fwd_data1 !== ed1)
            begin bad++; $display("FAIL rnd_fwd1 c%0d: got %b/%0h want %b/%0h", n, fwd_hit1, fwd_data1, eh1, ed1); end
         total++; if (fwd_hit2 !== eh2 || fwd_data2 !== ed2)
            begin bad++; $display("FAIL rnd_fwd2 c%0d: got %b/%0h want %b/%0h", n, fwd_hit2, fwd_data2, eh2, ed2); end
         tick();
      end
      drive(0, 0, 0, 0);
      for (int i = 0; i < 8 && q.size() > 0; i++) tick();
      #1;
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL rnd_drain: got empty=%b want 1", empty); end
   endtask

   initial begin
      drive(0, 0, 0, 0); fwd_reg1 = 5'd0; fwd_reg2 = 5'd0;
      test_reset();
      test_single_write();
      test_stall_fill();
      test_forward();
      test_xzr();
      test_mid_reset();
      test_coalesce();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
